// File: rtl/decrypt_pkg.sv
// Shared defaults, segment-count helper and field offsets for the decrypt pipeline.
package decrypt_pkg;

    localparam int          DEF_KEY_W           = 11;
    localparam int          DEF_DATA_W          = 60;
    localparam int          DEF_TAG_W           = 6;
    localparam logic [31:0] DEFAULT_INV_PATTERN = 32'h16;

    function automatic int nseg(input int data_w, input int key_w);
        return (data_w + key_w - 1) / key_w;
    endfunction

    // Input word layout, LSB first: tag, cipher (DATA_W+1 bits), key.
    function automatic int tag_lsb();
        return 0;
    endfunction

    function automatic int cipher_lsb(input int tag_w);
        return tag_w;
    endfunction

    function automatic int key_lsb(input int data_w, input int tag_w);
        return tag_w + data_w + 1;
    endfunction

    function automatic int in_width(input int key_w, input int data_w, input int tag_w);
        return key_w + data_w + 1 + tag_w;
    endfunction

endpackage

// File: rtl/decrypt_pipe_if.sv
// Valid/ready stream bundle for decrypt_pipe; borrow outputs exist only with DEC_BORROW_EN.
interface decrypt_pipe_if
    import decrypt_pkg::*;
#(
    parameter int KEY_W  = DEF_KEY_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
);
    localparam int IN_W = in_width(KEY_W, DATA_W, TAG_W);

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_dec_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
`ifdef DEC_BORROW_EN
    logic              out_borrow;
    logic [15:0]       borrow_cnt;
`endif

    modport slave (
        input  in_valid, in_data, in_dec_en, out_ready,
        output in_ready, out_valid, out_data, out_tag
`ifdef DEC_BORROW_EN
        , output out_borrow, borrow_cnt
`endif
    );

    modport master (
        output in_valid, in_data, in_dec_en, out_ready,
        input  in_ready, out_valid, out_data, out_tag
`ifdef DEC_BORROW_EN
        , input out_borrow, borrow_cnt
`endif
    );

endinterface

// File: rtl/decrypt_mask_gen.sv
// Combinational key expansion: key repeated per KEY_W-bit segment, segment i inverted when INV_PATTERN[i].
module decrypt_mask_gen
    import decrypt_pkg::*;
#(
    parameter int          KEY_W       = DEF_KEY_W,
    parameter int          DATA_W      = DEF_DATA_W,
    parameter logic [31:0] INV_PATTERN = DEFAULT_INV_PATTERN
) (
    input  logic [KEY_W-1:0]  key,
    output logic [DATA_W-1:0] mask
);
    localparam int NSEG = nseg(DATA_W, KEY_W);

    // Bits beyond DATA_W in the last segment are simply never generated.
    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        for (genvar k = 0; k < KEY_W; k++) begin : g_bit
            if (i * KEY_W + k < DATA_W) begin : g_live
                assign mask[i*KEY_W+k] = key[k] ^ INV_PATTERN[i];
            end
        end
    end

endmodule

// File: rtl/decrypt_pipe.sv
// Two-stage valid/ready decryptor: S1 holds mask/cipher, S2 holds plaintext.
// Define DEC_BORROW_EN to add the out_borrow flag and saturating borrow_cnt.
module decrypt_pipe
    import decrypt_pkg::*;
#(
    parameter int          KEY_W       = DEF_KEY_W,
    parameter int          DATA_W      = DEF_DATA_W,
    parameter int          TAG_W       = DEF_TAG_W,
    parameter logic [31:0] INV_PATTERN = DEFAULT_INV_PATTERN
) (
    input  logic           clk,
    input  logic           rst,
    decrypt_pipe_if.slave  bus
);
    localparam int KEY_LSB = key_lsb(DATA_W, TAG_W);
    localparam int Y_LSB   = cipher_lsb(TAG_W);
    localparam int TAG_LSB = tag_lsb();
`ifdef DEC_BORROW_EN
    localparam int DIFF_W  = DATA_W + 1;
`else
    localparam int DIFF_W  = DATA_W;
`endif

    logic [KEY_W-1:0]  in_key;
    logic [DATA_W:0]   in_y;
    logic [TAG_W-1:0]  in_tag;
    logic [DATA_W-1:0] in_mask;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_mask;
    logic [DATA_W:0]   s1_y;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_dec;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic [TAG_W-1:0]  s2_tag;

    logic              s2_load;
    logic              in_ready;

    logic [DATA_W-1:0] y_hi;
    logic [DATA_W-1:0] b_hi;
    logic              borrow0;
    logic [DIFF_W-1:0] diff;

    assign in_key = bus.in_data[KEY_LSB +: KEY_W];
    assign in_y   = bus.in_data[Y_LSB +: DATA_W+1];
    assign in_tag = bus.in_data[TAG_LSB +: TAG_W];

    decrypt_mask_gen #(
        .KEY_W       (KEY_W),
        .DATA_W      (DATA_W),
        .INV_PATTERN (INV_PATTERN)
    ) u_mask_gen (
        .key  (in_key),
        .mask (in_mask)
    );

    assign s2_load  = ~s2_valid | bus.out_ready;
    assign in_ready = ~s1_valid | s2_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mask  <= '0;
            s1_y     <= '0;
            s1_tag   <= '0;
            s1_dec   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_mask <= in_mask;
                s1_y    <= in_y;
                s1_tag  <= in_tag;
                s1_dec  <= bus.in_dec_en;
            end
        end
    end

    // The dropped LSB only contributes its borrow into the upper bits,
    // so the subtraction is done on the kept bits plus that borrow.
    assign y_hi    = s1_y[DATA_W:1];
    assign b_hi    = s1_mask >> 1;
    assign borrow0 = ~s1_y[0] & s1_mask[0];
    assign diff    = DIFF_W'(y_hi) - DIFF_W'(b_hi) - DIFF_W'(borrow0);

`ifdef DEC_BORROW_EN
    logic        s2_borrow;
    logic [15:0] borrow_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_borrow <= 1'b0;
        end else if (s2_load && s1_valid) begin
            s2_borrow <= s1_dec & diff[DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            borrow_cnt <= '0;
        end else if (s2_valid && bus.out_ready && s2_borrow && (borrow_cnt != 16'hFFFF)) begin
            borrow_cnt <= borrow_cnt + 16'd1;
        end
    end

    assign bus.out_borrow = s2_borrow;
    assign bus.borrow_cnt = borrow_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_dec ? diff[DATA_W-1:0] : y_hi;
                s2_tag  <= s1_tag;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_tag   = s2_tag;

endmodule

// File: tb/tb_decrypt_pipe.sv
// Self-checking bench for decrypt_pipe (default parameters); borrow checks when DEC_BORROW_EN is defined.
module tb_decrypt_pipe;
    import decrypt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decrypt_pipe_if bus ();

    decrypt_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [59:0] data;
        logic [5:0]  tag;
        logic        borrow;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cnt_model = 0;
    logic        lat_chk = 1'b1;
    int          last_drain = 0;
    logic [59:0] last_data;
    logic [5:0]  last_tag;
    logic        last_borrow;

    logic [10:0] cur_key;
    logic [60:0] cur_y;
    logic [5:0]  cur_tag;
    logic        cur_dec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: mask bit j is key bit (j mod 11), inverted when segment j/11 is marked in 0x16.
    function automatic logic [59:0] mask_of(input logic [10:0] key);
        logic [31:0] inv;
        logic [59:0] m;
        inv = 32'h16;
        for (int j = 0; j < 60; j++) m[j] = key[j % 11] ^ inv[j / 11];
        return m;
    endfunction

    function automatic exp_t model(input logic [10:0] key, input logic [60:0] y,
                                   input logic [5:0] tag, input logic dec);
        exp_t        e;
        logic [60:0] b;
        logic [60:0] x;
        b        = {1'b0, mask_of(key)};
        x        = y - b;
        e.data   = dec ? x[60:1] : y[60:1];
        e.borrow = dec && (y < b);
        e.tag    = tag;
        e.cyc    = 0;
        return e;
    endfunction

    task automatic drive(input logic [10:0] key, input logic [60:0] y,
                         input logic [5:0] tag, input logic dec);
        cur_key       = key;
        cur_y         = y;
        cur_tag       = tag;
        cur_dec       = dec;
        bus.in_data   = {key, y, tag};
        bus.in_dec_en = dec;
        bus.in_valid  = 1'b1;
    endtask

    task automatic drive_rand();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        drive(11'($urandom()), r[60:0], 6'($urandom()), ($urandom_range(0, 3) != 0));
    endtask

    // One clock: score any draining beat, log any accepted beat, advance to the next negedge.
    task automatic tick(output logic acc);
        exp_t e;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("data", 64'(bus.out_data), 64'(e.data));
                chk("tag", 64'(bus.out_tag), 64'(e.tag));
`ifdef DEC_BORROW_EN
                chk("borrow", 64'(bus.out_borrow), 64'(e.borrow));
`endif
                if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd2);
                if (e.borrow && cnt_model < 65535) cnt_model++;
                last_data   = bus.out_data;
                last_tag    = bus.out_tag;
                last_borrow = e.borrow;
                last_drain  = cyc;
            end
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            e     = model(cur_key, cur_y, cur_tag, cur_dec);
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_beat(input logic [10:0] key, input logic [60:0] y,
                            input logic [5:0] tag, input logic dec);
        logic acc;
        int   n;
        drive(key, y, tag, dec);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 4) begin
            tick(acc);
            n++;
        end
        chk("accept", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 8) begin
            tick(acc);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic        acc;
        int          first_acc;
        int          accepted;
        int          n;
        logic [59:0] m_a;
        logic [60:0] b_b;
        logic [60:0] x_b;
        logic [64:0] y_full;
        logic [59:0] held;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_dec_en = 1'b0;
        bus.out_ready = 1'b1;
        cur_key = '0; cur_y = '0; cur_tag = '0; cur_dec = 1'b0;
        held = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
`ifdef DEC_BORROW_EN
        chk("rst_borrow", 64'(bus.out_borrow), 64'd0);
        chk("rst_cnt", 64'(bus.borrow_cnt), 64'd0);
`endif
        rst = 1'b0;

        // Key all ones: mask equals y, plaintext zero
        m_a = '0;
        m_a[10:0]  = '1;
        m_a[43:33] = '1;
        m_a[59:55] = '1;
        run_beat(11'h7FF, {1'b0, m_a}, 6'h2A, 1'b1);
        chk("A_data", 64'(last_data), 64'd0);
        chk("A_tag", 64'(last_tag), 64'h2A);
`ifdef DEC_BORROW_EN
        chk("A_cnt", 64'(bus.borrow_cnt), 64'd0);
`endif

        // Key zero, y zero: underflow
        b_b = '0;
        b_b[32:11] = '1;
        b_b[54:44] = '1;
        x_b = 61'd0 - b_b;
        run_beat(11'h000, 61'd0, 6'h05, 1'b1);
        chk("B_data", 64'(last_data), 64'(x_b[60:1]));
        chk("B_borrow_model", 64'(last_borrow), 64'd1);
`ifdef DEC_BORROW_EN
        chk("B_cnt", 64'(bus.borrow_cnt), 64'd1);
`endif

        // Bypass: mask ignored
        y_full = 65'h1_2345_6789_ABCD_EF01;
        run_beat(11'h5A5, y_full[60:0], 6'h15, 1'b0);
        chk("C_data", 64'(last_data), 64'(y_full[60:1]));
        chk("C_tag", 64'(last_tag), 64'h15);

        // 100 random back-to-back beats
        first_acc = cyc;
        for (int i = 0; i < 100; i++) begin
            drive_rand();
            tick(acc);
            chk("rnd_accept", 64'(acc), 64'd1);
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 6) begin
            tick(acc);
            n++;
        end
        chk("rnd_drain", 64'(sb.size()), 64'd0);
        chk("rnd_throughput", 64'(last_drain - first_acc), 64'd101);
`ifdef DEC_BORROW_EN
        chk("rnd_cnt", 64'(bus.borrow_cnt), 64'(cnt_model));
`endif

        // Backpressure: out_ready low for 5 cycles with input always offered
        lat_chk       = 1'b0;
        bus.out_ready = 1'b0;
        accepted      = 0;
        drive_rand();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready", 64'(bus.in_ready), 64'(accepted < 2));
            if (k == 2) held = bus.out_data;
            if (k > 2) begin
                chk("bp_hold_data", 64'(bus.out_data), 64'(held));
                chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            end
            tick(acc);
            if (acc) begin
                accepted++;
                drive_rand();
            end
        end
        chk("bp_accepts", 64'(accepted), 64'd2);
        bus.out_ready = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 4) begin
            tick(acc);
            n++;
        end
        chk("bp_pending_accept", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 8) begin
            tick(acc);
            n++;
        end
        chk("bp_drain", 64'(sb.size()), 64'd0);
`ifdef DEC_BORROW_EN
        chk("bp_cnt", 64'(bus.borrow_cnt), 64'(cnt_model));
`endif

        // Reset mid-stream with two beats in flight
        lat_chk = 1'b1;
        drive_rand();
        tick(acc);
        drive_rand();
        tick(acc);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_out_data", 64'(bus.out_data), 64'd0);
`ifdef DEC_BORROW_EN
        chk("mid_rst_cnt", 64'(bus.borrow_cnt), 64'd0);
`endif
        sb.delete();
        cnt_model = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        #1;
        chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        cyc++;
        drive_rand();
        run_beat(cur_key, cur_y, cur_tag, cur_dec);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
